// File: rtl/uart_led_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_ctrl
//
// Decodes single-byte commands from the UART receive path and drives the
// board LED in OFF, ON or BLINK mode with a programmable blink half-period.
//
// Commands (decoded in IDLE):
//   0x41 'A' : LED on
//   0x42 'B' : LED off
//   0x43 'C' : blink, restarting the waveform with the LED high
//   0x44 'D' : the next byte is the blink half-period in ticks (0 loads as 1)
//   others   : one-cycle o_cmd_err pulse
// A missing argument byte is abandoned after TIMEOUT_CYCLES cycles, with an
// o_cmd_err pulse and the period left unchanged.
//
// Parameters:
//   PRESCALE       : clock cycles per blink tick (>= 1)
//   DEFAULT_PERIOD : blink half-period in ticks, loaded at reset
//   TIMEOUT_CYCLES : maximum cycles spent waiting for an argument (>= 1)
//
// Ports:
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   i_data          : received byte, valid while i_ready_to_read is high
//   i_ready_to_read : byte-available level strobe; one byte per rising edge
//   o_led           : LED drive (registered)
//   o_busy          : high while waiting for an argument byte (registered)
//   o_cmd_err       : one-cycle pulse on unknown opcode or argument timeout
// -----------------------------------------------------------------------------
module uart_led_cmd_ctrl #(
    parameter int         PRESCALE       = 1000000,
    parameter logic [7:0] DEFAULT_PERIOD = 8'd4,
    parameter int         TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_ready_to_read,
    output logic       o_led,
    output logic       o_busy,
    output logic       o_cmd_err
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    localparam logic [7:0] OP_ON    = 8'h41;
    localparam logic [7:0] OP_OFF   = 8'h42;
    localparam logic [7:0] OP_BLINK = 8'h43;
    localparam logic [7:0] OP_ARG   = 8'h44;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARG  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2
    } mode_t;

    // Input stage
    logic [7:0]      data_q;
    logic            rdy_q;
    logic            rdy_prev_q;

    // Control state
    state_t          state_q,    state_d;
    mode_t           mode_q,     mode_d;
    logic [7:0]      period_q,   period_d;
    logic            phase_q,    phase_d;
    logic [PS_W-1:0] ps_cnt_q,   ps_cnt_d;
    logic [7:0]      tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0] to_cnt_q,   to_cnt_d;

    // Registered outputs
    logic            led_q,  led_d;
    logic            busy_q, busy_d;
    logic            err_q,  err_d;

    logic            accept_s;
    logic            tick_s;

    // A held strobe yields a single byte: only its rising edge is accepted.
    assign accept_s = rdy_q & ~rdy_prev_q;
    assign tick_s   = (ps_cnt_q == PS_LAST);

    // Next-state logic: blink engine first, then command decode overrides it.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        phase_d    = phase_q;
        ps_cnt_d   = ps_cnt_q;
        tick_cnt_d = tick_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = 1'b0;
        led_d      = 1'b0;
        busy_d     = 1'b0;

        // Blink engine; counters sit at zero outside BLINK.
        if (mode_q == M_BLINK) begin
            if (tick_s) begin
                ps_cnt_d = '0;
                if (tick_cnt_q == (period_q - 8'd1)) begin
                    tick_cnt_d = 8'd0;
                    phase_d    = ~phase_q;
                end else begin
                    tick_cnt_d = tick_cnt_q + 8'd1;
                end
            end else begin
                ps_cnt_d = ps_cnt_q + PS_ONE;
            end
        end else begin
            ps_cnt_d   = '0;
            tick_cnt_d = 8'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (data_q)
                        OP_ON: begin
                            mode_d     = M_ON;
                            ps_cnt_d   = '0;
                            tick_cnt_d = 8'd0;
                        end
                        OP_OFF: begin
                            mode_d     = M_OFF;
                            ps_cnt_d   = '0;
                            tick_cnt_d = 8'd0;
                        end
                        OP_BLINK: begin
                            mode_d     = M_BLINK;
                            phase_d    = 1'b1;
                            ps_cnt_d   = '0;
                            tick_cnt_d = 8'd0;
                        end
                        OP_ARG: begin
                            state_d  = S_ARG;
                            to_cnt_d = '0;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARG: begin
                // An argument arriving on the timeout cycle still wins.
                if (accept_s) begin
                    period_d   = (data_q == 8'h00) ? 8'd1 : data_q;
                    ps_cnt_d   = '0;
                    tick_cnt_d = 8'd0;
                    phase_d    = phase_q;
                    to_cnt_d   = '0;
                    state_d    = S_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (mode_d)
            M_ON:    led_d = 1'b1;
            M_BLINK: led_d = phase_d;
            M_OFF:   led_d = 1'b0;
            default: led_d = 1'b0;
        endcase

        busy_d = (state_d == S_ARG);
    end

    // Input capture, control state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= 8'h00;
            rdy_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            mode_q     <= M_OFF;
            period_q   <= DEFAULT_PERIOD;
            phase_q    <= 1'b0;
            ps_cnt_q   <= '0;
            tick_cnt_q <= 8'd0;
            to_cnt_q   <= '0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_q     <= i_data;
            rdy_q      <= i_ready_to_read;
            rdy_prev_q <= rdy_q;
            state_q    <= state_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
            ps_cnt_q   <= ps_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            to_cnt_q   <= to_cnt_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_led     = led_q;
    assign o_busy    = busy_q;
    assign o_cmd_err = err_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for uart_led_cmd_ctrl (PRESCALE=4, TIMEOUT_CYCLES=20).
// A directed vector table, hand-written multi-cycle sequences and a random
// phase, all compared every cycle against a behavioural model that derives the
// blink phase arithmetically from the elapsed time since the last restart.
// -----------------------------------------------------------------------------
module tb_uart_led_cmd_ctrl;

    localparam int P  = 4;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_ready_to_read = 1'b0;
    logic       o_led;
    logic       o_busy;
    logic       o_cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_led_cmd_ctrl #(
        .PRESCALE       (P),
        .DEFAULT_PERIOD (8'd4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_data          (i_data),
        .i_ready_to_read (i_ready_to_read),
        .o_led           (o_led),
        .o_busy          (o_busy),
        .o_cmd_err       (o_cmd_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_mode;      // 0 off, 1 on, 2 blink
    bit         m_arg;       // waiting for argument
    int         m_wait;      // cycles spent waiting
    int         m_period;
    int         m_t0;        // edge index of last waveform restart
    bit         m_ph0;       // phase at restart
    int         m_n;         // edge index
    bit         m_err;
    bit         cap_rdy;
    bit         cap_prev;
    logic [7:0] cap_data;

    function automatic bit m_phase_at(input int t);
        int halves;
        halves = (t - m_t0) / (m_period * P);
        return m_ph0 ^ ((halves % 2) != 0);
    endfunction

    function automatic bit m_led();
        if (m_mode == 1) return 1'b1;
        if (m_mode == 2) return m_phase_at(m_n);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_arg = 0; m_wait = 0; m_period = 4;
        m_t0 = 0; m_ph0 = 0; m_n = 0; m_err = 0;
        cap_rdy = 0; cap_prev = 0; cap_data = 8'h00;
    endtask

    task automatic model_edge(input logic [7:0] d, input logic r);
        bit         acc;
        logic [7:0] b;
        acc      = cap_rdy && !cap_prev;
        b        = cap_data;
        cap_prev = cap_rdy;
        cap_rdy  = r;
        cap_data = d;
        m_n      = m_n + 1;
        m_err    = 0;
        if (!m_arg) begin
            if (acc) begin
                if (b == 8'h41) m_mode = 1;
                else if (b == 8'h42) m_mode = 0;
                else if (b == 8'h43) begin m_mode = 2; m_ph0 = 1; m_t0 = m_n; end
                else if (b == 8'h44) begin m_arg = 1; m_wait = 0; end
                else m_err = 1;
            end
        end else if (acc) begin
            m_ph0    = m_phase_at(m_n - 1);
            m_t0     = m_n;
            m_period = (b == 8'h00) ? 1 : int'(b);
            m_arg    = 0;
        end else begin
            m_wait = m_wait + 1;
            if (m_wait == TO) begin m_arg = 0; m_err = 1; end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of input, advance the model, compare all outputs.
    task automatic step(input logic [7:0] d, input logic r);
        i_data          = d;
        i_ready_to_read = r;
        @(posedge clk);
        model_edge(d, r);
        #1;
        check("model_led",  o_led,     m_led());
        check("model_busy", o_busy,    m_arg);
        check("model_err",  o_cmd_err, m_err);
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1);
        step(8'h00, 1'b0);
    endtask

    // Length of the current LED run, counting the present cycle.
    task automatic measure_run(input logic level, input int exp, input string name);
        int cnt;
        bit done;
        cnt  = 1;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(8'h00, 1'b0);
            if (o_led === level) cnt++;
            else done = 1;
        end
        check_int(name, cnt, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       led;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        bit         lvl;
        bit         rnd_rdy;
        logic [7:0] rnd_data;

        // ON/OFF, unknown opcode, held 'D' strobe, zero argument, ON again
        tbl[0]  = '{8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8'h42, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h44, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        #12;
        check("reset_led",  o_led,     1'b0);
        check("reset_busy", o_busy,    1'b0);
        check("reset_err",  o_cmd_err, 1'b0);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].data, tbl[i].rdy);
            check($sformatf("tbl%0d_led", i),  o_led,     tbl[i].led);
            check($sformatf("tbl%0d_busy", i), o_busy,    tbl[i].busy);
            check($sformatf("tbl%0d_err", i),  o_cmd_err, tbl[i].err);
        end

        // Period stored as 1 -> 4-cycle half-periods
        send(8'h43);
        check("zero_period_start", o_led, 1'b1);
        measure_run(1'b1, 4, "zero_period_high");
        measure_run(1'b0, 4, "zero_period_low");

        // Async reset mid-blink, with a 'C' strobe already high at release
        step(8'h00, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_led",  o_led,  1'b0);
        check("async_rst_busy", o_busy, 1'b0);
        i_data = 8'h43;
        i_ready_to_read = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        step(8'h43, 1'b1);
        step(8'h43, 1'b1);
        check("held_at_release_led", o_led, 1'b1);
        measure_run(1'b1, 16, "default_blink_high");
        measure_run(1'b0, 16, "default_blink_low");

        // Argument timeout: error 21 edges after the 'D' is captured
        step(8'h44, 1'b1);
        c = 0;
        step(8'h00, 1'b0);
        c = 1;
        check("timeout_busy_set", o_busy, 1'b1);
        while (c < 40 && o_cmd_err !== 1'b1) begin
            step(8'h00, 1'b0);
            c++;
        end
        check_int("timeout_cycles", c, 21);
        check("timeout_busy_clr", o_busy, 1'b0);
        step(8'h00, 1'b0);
        check("timeout_err_one_cycle", o_cmd_err, 1'b0);
        send(8'h43);
        measure_run(1'b1, 16, "period_kept_after_timeout");

        // Argument decoded on the cycle the timeout would fire
        step(8'h44, 1'b1);
        step(8'h00, 1'b0);
        for (int i = 0; i < 18; i++) step(8'h00, 1'b0);
        step(8'h03, 1'b1);
        check("race_busy_before", o_busy, 1'b1);
        step(8'h00, 1'b0);
        check("race_no_err", o_cmd_err, 1'b0);
        check("race_busy_clr", o_busy, 1'b0);
        send(8'h43);
        measure_run(1'b1, 12, "race_period3_high");

        // Period change mid-blink: phase holds for 8, then toggles every 8
        step(8'h44, 1'b1);
        step(8'h00, 1'b0);
        check("pchg_busy", o_busy, 1'b1);
        step(8'h00, 1'b0);
        step(8'h02, 1'b1);
        step(8'h00, 1'b0);
        check("pchg_busy_clr", o_busy, 1'b0);
        lvl = o_led;
        measure_run(lvl,  8, "pchg_hold");
        measure_run(!lvl, 8, "pchg_toggle1");
        measure_run(lvl,  8, "pchg_toggle2");

        // Randomised strobes against the model
        rnd_rdy  = 1'b0;
        rnd_data = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if (rnd_rdy) begin
                if ($urandom_range(0, 1) == 0) rnd_rdy = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                rnd_rdy = 1'b1;
                case ($urandom_range(0, 11))
                    0:       rnd_data = 8'h41;
                    1:       rnd_data = 8'h42;
                    2, 3:    rnd_data = 8'h43;
                    4, 5:    rnd_data = 8'h44;
                    6:       rnd_data = 8'h00;
                    7:       rnd_data = 8'h01;
                    8:       rnd_data = 8'h02;
                    9:       rnd_data = 8'h03;
                    10:      rnd_data = 8'($urandom_range(0, 255));
                    default: rnd_data = 8'h5A;
                endcase
            end
            if (rnd_rdy) step(rnd_data, 1'b1);
            else step(8'($urandom_range(0, 255)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
